// File: rtl/vga_sync_gen.sv
//==============================================================================
// Module   : vga_sync_gen
// Brief    : VGA pixel-timing generator. Free-running x/y raster counters with
//            registered hsync/vsync (active-low), display-active flag and
//            frame-start pulse, all aligned with the pixel coordinates shown.
//            Optional macro VGA_SYNC_FRAME_COUNT_EN builds a 16-bit counter of
//            frames entered; without it frame_count is tied to zero.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        pixel_en,
    output logic        hsync,
    output logic        vsync,
    output logic        active,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    // Raster totals; both must fit the 10-bit coordinate counters.
    localparam int c_h_total = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_v_total = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Region boundaries are 11 bits wide so a sync pulse ending exactly at
    // 1024 (zero back porch with a 1024 total) still compares correctly.
    localparam logic [10:0] c_h_act    = 11'(H_ACTIVE);
    localparam logic [10:0] c_hs_begin = 11'(H_ACTIVE + H_FRONT);
    localparam logic [10:0] c_hs_end   = 11'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [10:0] c_v_act    = 11'(V_ACTIVE);
    localparam logic [10:0] c_vs_begin = 11'(V_ACTIVE + V_FRONT);
    localparam logic [10:0] c_vs_end   = 11'(V_ACTIVE + V_FRONT + V_SYNC);

    // Last coordinate of each axis; this is also the reset position so that
    // the first enabled edge after reset lands on (0,0).
    localparam logic [9:0] c_x_last = 10'(c_h_total - 1);
    localparam logic [9:0] c_y_last = 10'(c_v_total - 1);

    // Reject geometries that overflow the 10-bit coordinate outputs.
    generate
        if (c_h_total > 1024) begin : g_h_total_check
            $error("vga_sync_gen: horizontal total %0d exceeds 1024", c_h_total);
        end
        if (c_v_total > 1024) begin : g_v_total_check
            $error("vga_sync_gen: vertical total %0d exceeds 1024", c_v_total);
        end
    endgenerate

    // Registered state: coordinates plus their decoded region flags.
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_active;
    logic       r_frame_start;

    // Next-state counters and the decode of that next position.
    logic        w_x_wrap;
    logic [9:0]  w_x_next;
    logic [9:0]  w_y_next;
    logic [10:0] w_x_ext;
    logic [10:0] w_y_ext;
    logic        w_active_next;
    logic        w_hsync_next;
    logic        w_vsync_next;
    logic        w_frame_next;

    // Advance the raster position and decode regions of the position it moves to,
    // so the registered flags describe the coordinates registered alongside them.
    always_comb begin
        w_x_wrap      = 1'b0;
        w_x_next      = r_x;
        w_y_next      = r_y;
        w_x_ext       = 11'd0;
        w_y_ext       = 11'd0;
        w_active_next = 1'b0;
        w_hsync_next  = 1'b1;
        w_vsync_next  = 1'b1;
        w_frame_next  = 1'b0;

        w_x_wrap = (r_x == c_x_last);
        if (w_x_wrap) begin
            w_x_next = 10'd0;
            if (r_y == c_y_last) begin
                w_y_next = 10'd0;
            end else begin
                w_y_next = r_y + 10'd1;
            end
        end else begin
            w_x_next = r_x + 10'd1;
        end

        w_x_ext       = {1'b0, w_x_next};
        w_y_ext       = {1'b0, w_y_next};
        w_active_next = (w_x_ext < c_h_act) && (w_y_ext < c_v_act);
        w_hsync_next  = !((w_x_ext >= c_hs_begin) && (w_x_ext < c_hs_end));
        w_vsync_next  = !((w_y_ext >= c_vs_begin) && (w_y_ext < c_vs_end));
        w_frame_next  = (w_x_next == 10'd0) && (w_y_next == 10'd0);
    end

    // Raster state register: everything holds while pixel_en is low.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_x           <= c_x_last;
            r_y           <= c_y_last;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_active      <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (pixel_en) begin
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_hsync       <= w_hsync_next;
            r_vsync       <= w_vsync_next;
            r_active      <= w_active_next;
            r_frame_start <= w_frame_next;
        end
    end

    assign pixel_x     = r_x;
    assign pixel_y     = r_y;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign active      = r_active;
    assign frame_start = r_frame_start;

`ifdef VGA_SYNC_FRAME_COUNT_EN
    logic [15:0] r_frame_count;

    // Count every enabled step into (0,0); wraps naturally at 2^16.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_count <= 16'd0;
        end else if (pixel_en && w_frame_next) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign frame_count = r_frame_count;
`else
    assign frame_count = 16'd0;
`endif

endmodule

`default_nettype wire
